// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V memory stage: funct3 encodings for
// branches and loads/stores, and the data-memory handshake state type.
package riscv_pkg;

  // Load/store size encodings
  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;

  // Branch condition encodings
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for loads and stores. Produces store byte enables and
// replicated write data, extracts and extends load data, and flags accesses
// that are misaligned for their size.
// Optional macro: MEM_MISALIGN_TRAP_EN enables misalignment detection;
// without it, low address bits below the access size are ignored.
module load_store_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Size-aligned byte offset, store enables and lane-replicated store data
  always_comb begin
    off   = 2'b00;
    be    = 4'b1111;
    wdata = rs2;
    case (funct3[1:0])
      2'b00: begin
        off   = addr_lo;
        be    = 4'b0001 << addr_lo;
        wdata = {4{rs2[7:0]}};
      end
      2'b01: begin
        off   = {addr_lo[1], 1'b0};
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{rs2[15:0]}};
      end
      default: begin
        off   = 2'b00;
        be    = 4'b1111;
        wdata = rs2;
      end
    endcase
  end

  // Load lane extraction with sign or zero extension
  always_comb begin
    ld_byte   = rdata[{off, 3'b000} +: 8];
    ld_half   = off[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   load_data = {24'h000000, ld_byte};
      F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   load_data = {16'h0000, ld_half};
      default: load_data = rdata;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Halfwords need an even address, words a multiple of four
  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr_lo[0];
      default: misaligned = (addr_lo != 2'b00);
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/memory_access.sv
// Memory stage of the five-stage RISC-V pipeline: branch resolution,
// ready-handshaked data-memory access with stall, and the MEM/WB register.
// Optional macro: MEM_MISALIGN_TRAP_EN (misaligned accesses are suppressed
// and reported through misalign_from_memory).
module memory_access
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] branch_addr_from_execution,
  input  logic [31:0] result_from_execution,
  input  logic [31:0] rs2_data_from_execution,
  input  logic        equal_from_execution,
  input  logic        greater_from_execution,
  input  logic        lesser_from_execution,
  input  logic [2:0]  funct3_from_execution,
  input  logic [4:0]  rd_from_execution,
  input  logic        write_reg_from_execution,
  input  logic        select_from_execution,
  input  logic        read_from_execution,
  input  logic        write_from_execution,
  input  logic        branch_from_execution,
  input  logic        u_branch_from_execution,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        pc_src_from_memory,
  output logic [31:0] branch_target_from_memory,
  output logic        stall_from_memory,
  output logic [31:0] result_from_memory,
  output logic [4:0]  rd_from_memory,
  output logic        write_reg_from_memory,
  output logic        misalign_from_memory
);

  mem_state_t  state_q, state_d;
  logic        access, trap, access_ok;
  logic        req, stall, cond;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;
  logic        misaligned;
  logic        unused_greater;

  // Signed/unsigned ordering arrives pre-resolved on lesser; greater is not needed
  assign unused_greater = greater_from_execution;

  load_store_align u_align (
    .funct3    (funct3_from_execution),
    .addr_lo   (result_from_execution[1:0]),
    .rs2       (rs2_data_from_execution),
    .rdata     (dmem_rdata),
    .be        (st_be),
    .wdata     (st_wdata),
    .load_data (ld_data),
    .misaligned(misaligned)
  );

  // Branch condition decode from comparator flags
  always_comb begin
    cond = 1'b0;
    case (funct3_from_execution)
      F3_BEQ:           cond = equal_from_execution;
      F3_BNE:           cond = ~equal_from_execution;
      F3_BLT, F3_BLTU:  cond = lesser_from_execution;
      F3_BGE, F3_BGEU:  cond = ~lesser_from_execution;
      default:          cond = 1'b0;
    endcase
  end

  assign pc_src_from_memory        = u_branch_from_execution |
                                     (branch_from_execution & cond);
  assign branch_target_from_memory = branch_addr_from_execution;

  assign access    = read_from_execution | write_from_execution;
  assign trap      = access & misaligned;
  assign access_ok = access & ~misaligned;

  // Handshake state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state, request and stall; EX/MEM inputs are held upstream while stalled
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_ok) begin
          req = 1'b1;
          if (!dmem_ready) begin
            stall   = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        req = 1'b1;
        if (!dmem_ready) stall   = 1'b1;
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are gated by reset so a request in flight is dropped immediately
  assign dmem_req          = req & rst;
  assign dmem_we           = req & write_from_execution & ~read_from_execution & rst;
  assign stall_from_memory = stall & rst;
  assign dmem_addr         = {result_from_execution[31:2], 2'b00};
  assign dmem_be           = read_from_execution ? 4'b1111 : st_be;
  assign dmem_wdata        = st_wdata;

  // MEM/WB register; a stall or a trapped access inserts a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_from_memory    <= '0;
      rd_from_memory        <= '0;
      write_reg_from_memory <= 1'b0;
      misalign_from_memory  <= 1'b0;
    end else begin
      result_from_memory    <= select_from_execution ? ld_data : result_from_execution;
      rd_from_memory        <= rd_from_execution;
      write_reg_from_memory <= write_reg_from_execution & ~stall & ~trap;
      misalign_from_memory  <= trap;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed cases plus randomized
// branch/ALU/load/store operations against an arithmetic reference model.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] branch_addr_from_execution, result_from_execution, rs2_data_from_execution;
  logic        equal_from_execution, greater_from_execution, lesser_from_execution;
  logic [2:0]  funct3_from_execution;
  logic [4:0]  rd_from_execution;
  logic        write_reg_from_execution, select_from_execution, read_from_execution;
  logic        write_from_execution, branch_from_execution, u_branch_from_execution;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        pc_src_from_memory, stall_from_memory;
  logic [31:0] branch_target_from_memory, result_from_memory;
  logic [4:0]  rd_from_memory;
  logic        write_reg_from_memory, misalign_from_memory;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  memory_access dut (
    .clk(clk), .rst(rst),
    .branch_addr_from_execution(branch_addr_from_execution),
    .result_from_execution(result_from_execution),
    .rs2_data_from_execution(rs2_data_from_execution),
    .equal_from_execution(equal_from_execution),
    .greater_from_execution(greater_from_execution),
    .lesser_from_execution(lesser_from_execution),
    .funct3_from_execution(funct3_from_execution),
    .rd_from_execution(rd_from_execution),
    .write_reg_from_execution(write_reg_from_execution),
    .select_from_execution(select_from_execution),
    .read_from_execution(read_from_execution),
    .write_from_execution(write_from_execution),
    .branch_from_execution(branch_from_execution),
    .u_branch_from_execution(u_branch_from_execution),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .pc_src_from_memory(pc_src_from_memory),
    .branch_target_from_memory(branch_target_from_memory),
    .stall_from_memory(stall_from_memory),
    .result_from_memory(result_from_memory),
    .rd_from_memory(rd_from_memory),
    .write_reg_from_memory(write_reg_from_memory),
    .misalign_from_memory(misalign_from_memory)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model
  function automatic bit exp_taken(input logic [2:0] f3, input bit eq, input bit ls,
                                   input bit br, input bit ub);
    bit c;
    case (f3)
      3'd0:       c = eq;
      3'd1:       c = !eq;
      3'd4, 3'd6: c = ls;
      3'd5, 3'd7: c = !ls;
      default:    c = 1'b0;
    endcase
    return ub || (br && c);
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd_word);
    logic [31:0] v;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = (rd_word >> (8 * (a % 4))) & 32'hFF;
      if (f3 == 3'd0 && v >= 128) v = v - 256;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (rd_word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32768) v = v - 65536;
    end else begin
      v = rd_word;
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    if (f3 % 4 == 0)      return 4'(1 << (a % 4));
    else if (f3 % 4 == 1) return ((a / 2) % 2 == 1) ? 4'd12 : 4'd3;
    else                  return 4'd15;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 % 4 == 0)      return (d % 256) * 32'h01010101;
    else if (f3 % 4 == 1) return (d % 65536) * 32'h00010001;
    else                  return d;
  endfunction

  function automatic bit exp_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    if (f3 % 4 == 1)      return (a % 2) != 0;
    else if (f3 % 4 >= 2) return (a % 4) != 0;
    else                  return 1'b0;
`else
    return (f3 == 3'd7) && (a == 32'd1) && 1'b0;
`endif
  endfunction

  task automatic clear_inputs();
    branch_addr_from_execution = '0; result_from_execution = '0; rs2_data_from_execution = '0;
    equal_from_execution = 0; greater_from_execution = 0; lesser_from_execution = 0;
    funct3_from_execution = '0; rd_from_execution = '0; write_reg_from_execution = 0;
    select_from_execution = 0; read_from_execution = 0; write_from_execution = 0;
    branch_from_execution = 0; u_branch_from_execution = 0;
    dmem_ready = 0; dmem_rdata = '0;
  endtask

  // Non-memory op (branch or ALU); called just after a rising edge
  task automatic do_branch(input logic [2:0] f3, input bit eq, input bit ls, input bit br,
                           input bit ub, input logic [31:0] tgt, input logic [31:0] res,
                           input logic [4:0] rd, input bit wr);
    clear_inputs();
    funct3_from_execution = f3; equal_from_execution = eq; lesser_from_execution = ls;
    greater_from_execution = !eq && !ls;
    branch_from_execution = br; u_branch_from_execution = ub;
    branch_addr_from_execution = tgt; result_from_execution = res;
    rd_from_execution = rd; write_reg_from_execution = wr;
    dmem_ready = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    @(negedge clk);
    check("pc_src", pc_src_from_memory, exp_taken(f3, eq, ls, br, ub));
    check("target", branch_target_from_memory, tgt);
    check("alu_stall", stall_from_memory, 0);
    check("alu_req", dmem_req, 0);
    @(posedge clk); #1;
    check("alu_result", result_from_memory, res);
    check("alu_rd", rd_from_memory, rd);
    check("alu_wr", write_reg_from_memory, wr);
  endtask

  // Load or store with n_wait cycles of dmem_ready low; called just after a rising edge
  task automatic do_mem(input bit is_read, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd_word,
                        input int n_wait, input logic [4:0] rd);
    logic [31:0] exp_res;
    clear_inputs();
    funct3_from_execution = f3; result_from_execution = a; rs2_data_from_execution = d;
    read_from_execution = is_read; write_from_execution = !is_read;
    select_from_execution = is_read; write_reg_from_execution = is_read;
    rd_from_execution = rd; dmem_rdata = rd_word;
    exp_res = is_read ? exp_load(f3, a, rd_word) : a;
    if (exp_mis(f3, a)) begin
      dmem_ready = 1'b0;
      @(negedge clk);
      check("mis_req", dmem_req, 0);
      check("mis_stall", stall_from_memory, 0);
      @(posedge clk); #1;
      check("mis_pulse", misalign_from_memory, 1);
      check("mis_wr", write_reg_from_memory, 0);
      clear_inputs();
      @(posedge clk); #1;
      check("mis_pulse_end", misalign_from_memory, 0);
    end else begin
      for (int i = 0; i <= n_wait; i++) begin
        dmem_ready = (i == n_wait);
        @(negedge clk);
        check("stall", stall_from_memory, (i < n_wait) ? 1 : 0);
        check("req", dmem_req, 1);
        check("we", dmem_we, is_read ? 0 : 1);
        check("addr", dmem_addr, a - (a % 4));
        check("be", dmem_be, is_read ? 4'hF : exp_be(f3, a));
        if (!is_read) check("wdata", dmem_wdata, exp_wdata(f3, d));
        @(posedge clk); #1;
        if (i < n_wait) check("bubble", write_reg_from_memory, 0);
      end
      check("mem_result", result_from_memory, exp_res);
      check("mem_rd", rd_from_memory, rd);
      check("mem_wr", write_reg_from_memory, is_read ? 1 : 0);
      check("mem_mis", misalign_from_memory, 0);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result_from_memory, 0);
    check("rst_rd", rd_from_memory, 0);
    check("rst_wr", write_reg_from_memory, 0);
    check("rst_mis", misalign_from_memory, 0);
    check("rst_req", dmem_req, 0);
    rst = 1'b1;

    // Directed branch cases
    do_branch(3'b001, 0, 0, 1, 0, 32'h0000_4000, 32'h11, 5'd1, 1);
    check("bne_taken", pc_src_from_memory, 1);
    do_branch(3'b101, 0, 1, 1, 0, 32'h0000_5000, 32'h22, 5'd2, 1);
    do_branch(3'b010, 1, 1, 0, 1, 32'h0000_6000, 32'h33, 5'd3, 0);

    // SB with ready high, then LB / LBU with three wait cycles
    do_mem(0, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 5'd0);
    do_mem(1, 3'b000, 32'h0000_2003, 32'h0, 32'h8000_0000, 3, 5'd5);
    check("lb_value", result_from_memory, 32'hFFFF_FF80);
    do_mem(1, 3'b100, 32'h0000_2003, 32'h0, 32'h8000_0000, 3, 5'd5);
    check("lbu_value", result_from_memory, 32'h0000_0080);

    // LW at a non-word address: trapped with the macro, forced aligned without
    do_mem(1, 3'b010, 32'h0000_1002, 32'h0, 32'hCAFE_F00D, 1, 5'd7);

    // Reset asserted while waiting on memory
    clear_inputs();
    funct3_from_execution = 3'b000; result_from_execution = 32'h0000_2003;
    read_from_execution = 1; select_from_execution = 1; write_reg_from_execution = 1;
    rd_from_execution = 5'd5; dmem_rdata = 32'h8000_0000; dmem_ready = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("wait_stall", stall_from_memory, 1);
    #2 rst = 1'b0;
    #1;
    check("rw_req", dmem_req, 0);
    check("rw_we", dmem_we, 0);
    check("rw_stall", stall_from_memory, 0);
    check("rw_result", result_from_memory, 0);
    check("rw_rd", rd_from_memory, 0);
    check("rw_wr", write_reg_from_memory, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    clear_inputs();
    result_from_execution = 32'h0000_1234; write_reg_from_execution = 1; rd_from_execution = 5'd9;
    @(negedge clk);
    check("post_rst_stall", stall_from_memory, 0);
    check("post_rst_req", dmem_req, 0);
    @(posedge clk); #1;
    check("post_rst_result", result_from_memory, 32'h0000_1234);
    check("post_rst_wr", write_reg_from_memory, 1);

    // Randomized mix
    for (int n = 0; n < 200; n++) begin
      int unsigned kind;
      logic [2:0] f3;
      kind = $urandom_range(0, 3);
      case (kind)
        0, 1: do_branch(3'($urandom), 1'($urandom), 1'($urandom), kind == 0 ? 1'($urandom) : 1'b0,
                        1'($urandom_range(0, 3) == 0), $urandom, $urandom,
                        5'($urandom), 1'($urandom));
        2: begin
          case ($urandom_range(0, 4))
            0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
          endcase
          do_mem(1, f3, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)), 5'($urandom));
        end
        default: begin
          f3 = 3'($urandom_range(0, 2));
          do_mem(0, f3, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)), 5'($urandom));
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
